clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
- Controller that sequences the seconds/minutes/hours up-counter chain of the real-time clock.
- Generates the 1 Hz enable tick from the system clock and runs a set-time state machine driven by two push buttons.
- Produces load strobes and load values for the hour and minute counters, plus a seconds-clear request.
- Sits between board buttons/oscillator and the counter chain; the chain's count outputs feed back to it.

Parameters:
TICK_DIV, 50000000, system clocks per enable tick (>=2)
HRS_MAX, 23, terminal value of the hours field
MIN_MAX, 59, terminal value of the minutes field
TIMEOUT_TICKS, 10, ticks without a button press before SET states abandon edits (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset; all flops clear while reset=0
btn_mode  in  1  raw mode button, asynchronous, active-high
btn_inc  in  1  raw increment button, asynchronous, active-high
count_min  in  6  current minutes from the counter chain
count_hrs  in  6  current hours from the counter chain
en  out  1  one-cycle enable pulse into the seconds counter
load_hrs  out  1  one-cycle strobe: hours counter takes load_val
load_min  out  1  one-cycle strobe: minutes counter takes load_val
clr_sec_req  out  1  one-cycle strobe: seconds counter clears to 0
load_val  out  6  value being edited / loaded
mode  out  2  00 RUN, 01 SET_HRS, 10 SET_MIN
blink  out  1  display blink for the field under edit

Behaviour:
- Reset values: en=0, load_hrs=0, load_min=0, clr_sec_req=0, load_val=0, mode=RUN, blink=0, prescaler=0, timeout counter=0, synchronizer/edge flops=0.
- Prescaler:
  - Free-running in every state, counting 0..TICK_DIV-1 and wrapping to 0.
  - Internal tick is high for exactly one cycle when the count equals TICK_DIV-1.
  - en = tick AND mode==RUN, registered. en is high on the cycle after the prescaler reaches TICK_DIV-1.
  - en is never high in the SET states, so time freezes during editing.
- Buttons:
  - Each button passes through a 2-flop synchronizer and then a rising-edge detector.
  - The result is a one-cycle press pulse, 3 cycles after the raw rising edge.
  - A held button produces exactly one pulse.
- Mode press, by state:
  - RUN -> SET_HRS: load_val <= count_hrs.
  - SET_HRS -> SET_MIN: load_hrs=1 for one cycle with load_val still holding the edited hours. On the next cycle load_val <= count_min.
  - SET_MIN -> RUN: load_min=1 and clr_sec_req=1 in the same single cycle, with load_val holding the edited minutes.
- Mode encoding 11 is unreachable. If entered, the FSM goes to RUN on the next cycle with no strobes.
- Inc press:
  - SET_HRS: load_val <= (load_val>=HRS_MAX) ? 0 : load_val+1.
  - SET_MIN: same rule with MIN_MAX.
  - RUN: ignored.
  - A value above max wraps to 0 on the next increment.
- Simultaneous mode and inc pulses in the same cycle: mode is processed, inc is discarded.
- Timeout:
  - The counter clears on entry to any SET state and on every press.
  - It increments on each tick while in a SET state.
  - When it reaches TIMEOUT_TICKS, the FSM returns to RUN with no load_* or clr_sec_req strobes. Edits are discarded.
- Blink: toggles on each tick while in a SET state. Forced to 0 in RUN and on every state change.
- Strobes: load_hrs, load_min and clr_sec_req are mutually exclusive with en (never high together). Each is exactly one cycle wide.
- Reset mid-edit (reset low at any cycle): all outputs return to reset values immediately, with no strobe emitted. After reset release, en pulses resume from a prescaler count of 0.
- Width: all arithmetic is 6-bit unsigned; HRS_MAX and MIN_MAX must be <=63.

Test Plan:
- TICK_DIV=4, idle RUN for 20 cycles -> en pulses every 4 cycles. No load or clear strobes occur.
- count_hrs=22, mode press, inc x3 -> load_val 23, 0, 1. Then mode press -> load_hrs=1 with load_val=1, mode=SET_MIN, and load_val becomes count_min on the next cycle.
- In SET_MIN with load_val=58: inc x2 -> 59, 0. Mode press -> single cycle with load_min=1, clr_sec_req=1, load_val=0. mode=RUN; en resumes at the next tick.
- TIMEOUT_TICKS=3, TICK_DIV=4, enter SET_HRS, no presses -> after 3 ticks mode=RUN with zero load strobes. blink toggles at each tick before exit.
- Mode and inc raw edges aligned in the same cycle while in SET_HRS with load_val=5 -> transition to SET_MIN with load_hrs carrying 5. No increment occurs.
- Reset asserted in SET_MIN after two incs -> all outputs 0 and mode=RUN during reset. After release, no load_min is ever emitted for the aborted edit.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: enable-tick prescaler and two-button set-time FSM
// that drives load strobes into the RTC seconds/minutes/hours counter chain.
module clock_set_ctrl #(
    parameter int TICK_DIV      = 50000000,
    parameter int HRS_MAX       = 23,
    parameter int MIN_MAX       = 59,
    parameter int TIMEOUT_TICKS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [5:0] count_min,
    input  logic [5:0] count_hrs,
    output logic       en,
    output logic       load_hrs,
    output logic       load_min,
    output logic       clr_sec_req,
    output logic [5:0] load_val,
    output logic [1:0] mode,
    output logic       blink
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    typedef enum logic [1:0] {RUN = 2'b00, SET_HRS = 2'b01, SET_MIN = 2'b10, BAD = 2'b11} state_t;

    state_t        state, state_nx;
    logic [PW-1:0] pre;
    logic [TW-1:0] tcnt, tcnt_nx;
    logic [2:0]    sync_mode, sync_inc;
    logic [5:0]    val_nx;
    logic          tick, mode_p, inc_p, last, lh_nx, lm_nx, blink_nx;

    assign tick   = pre == PW'(TICK_DIV - 1);
    assign mode_p = sync_mode[1] & ~sync_mode[2];
    assign inc_p  = sync_inc[1] & ~sync_inc[2];
    assign last   = tick && tcnt >= TW'(TIMEOUT_TICKS - 1);
    assign mode   = state;

    always_comb begin
        state_nx = state;
        val_nx   = load_val;
        lh_nx    = 1'b0;
        lm_nx    = 1'b0;
        case (state)
            RUN: if (mode_p) begin
                state_nx = SET_HRS;
                val_nx   = count_hrs;
            end
            SET_HRS: if (mode_p) begin
                state_nx = SET_MIN;
                lh_nx    = 1'b1;
            end else if (inc_p) val_nx = (load_val >= 6'(HRS_MAX)) ? 6'd0 : load_val + 6'd1;
            else if (last) state_nx = RUN;
            SET_MIN: if (mode_p) begin
                state_nx = RUN;
                lm_nx    = 1'b1;
            // cycle right after the hours commit: pick up the live minutes
            end else if (load_hrs) val_nx = count_min;
            else if (inc_p) val_nx = (load_val >= 6'(MIN_MAX)) ? 6'd0 : load_val + 6'd1;
            else if (last) state_nx = RUN;
            default: state_nx = RUN;
        endcase
        tcnt_nx  = (state_nx != state || state_nx == RUN || mode_p || inc_p) ? '0 :
                   tick ? tcnt + TW'(1) : tcnt;
        blink_nx = (state_nx != state || state_nx == RUN) ? 1'b0 : blink ^ tick;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre         <= '0;
            sync_mode   <= '0;
            sync_inc    <= '0;
            state       <= RUN;
            tcnt        <= '0;
            load_val    <= '0;
            load_hrs    <= 1'b0;
            load_min    <= 1'b0;
            clr_sec_req <= 1'b0;
            blink       <= 1'b0;
            en          <= 1'b0;
        end else begin
            pre         <= tick ? '0 : pre + PW'(1);
            sync_mode   <= {sync_mode[1:0], btn_mode};
            sync_inc    <= {sync_inc[1:0], btn_inc};
            state       <= state_nx;
            tcnt        <= tcnt_nx;
            load_val    <= val_nx;
            load_hrs    <= lh_nx;
            load_min    <= lm_nx;
            clr_sec_req <= lm_nx;
            blink       <= blink_nx;
            en          <= tick && state == RUN;
        end
    end
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: scoreboard bench for clock_set_ctrl; expected strobe events
// are queued by the stimulus and popped by a monitor whenever a load strobe appears.
module tb_clock_set_ctrl;
    logic       clk = 1'b0, reset = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
    logic [5:0] count_min = 6'd0, count_hrs = 6'd0;
    logic       en, load_hrs, load_min, clr_sec_req, blink;
    logic [5:0] load_val;
    logic [1:0] mode;
    int         checks = 0, failures = 0;
    logic [10:0] sbq[$];

    clock_set_ctrl #(.TICK_DIV(4), .HRS_MAX(23), .MIN_MAX(59), .TIMEOUT_TICKS(3)) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .count_min(count_min), .count_hrs(count_hrs), .en(en), .load_hrs(load_hrs),
        .load_min(load_min), .clr_sec_req(clr_sec_req), .load_val(load_val),
        .mode(mode), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // press for two cycles, release, then let the synchronizer settle
    task automatic tap(input logic m, input logic i);
        btn_mode = m;
        btn_inc  = i;
        repeat (2) @(posedge clk);
        #1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic first_en(input string name);
        int first;
        first = 0;
        for (int i = 1; i <= 10 && first == 0; i++) begin
            @(negedge clk);
            if (en) first = i;
        end
        chk(name, first, 4);
    endtask

    // monitor: every load/clear strobe must match the head of the scoreboard
    initial forever begin
        @(negedge clk);
        if (reset && (load_hrs || load_min || clr_sec_req)) begin
            chk("strobe_vs_en", {31'd0, en}, 32'd0);
            if (sbq.size() == 0)
                chk("unexpected_strobe", {21'd0, load_hrs, load_min, clr_sec_req, load_val, mode}, 32'd0);
            else
                chk("strobe", {21'd0, load_hrs, load_min, clr_sec_req, load_val, mode}, {21'd0, sbq.pop_front()});
        end
    end

    initial begin
        int   n, prev, gap_bad, toggles, dwell, found;
        logic pb;
        repeat (2) @(negedge clk);
        chk("rst_outs", {en, load_hrs, load_min, clr_sec_req, blink}, 0);
        chk("rst_val", load_val, 0);
        chk("rst_mode", mode, 0);
        reset = 1'b1;
        first_en("first_en_after_rst");

        n = 0; prev = 0; gap_bad = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (en) begin
                if (prev != 0 && i - prev != 4) gap_bad++;
                prev = i;
                n++;
            end
        end
        chk("idle_en_count", n, 5);
        chk("idle_en_gap", gap_bad, 0);

        count_hrs = 6'd22;
        count_min = 6'd58;
        @(posedge clk); #1;
        tap(1, 0);
        chk("enter_hrs_mode", mode, 1);
        chk("enter_hrs_val", load_val, 22);
        tap(0, 1); chk("inc_23", load_val, 23);
        tap(0, 1); chk("inc_wrap_hrs", load_val, 0);
        tap(0, 1); chk("inc_1", load_val, 1);
        sbq.push_back({3'b100, 6'd1, 2'b10});
        tap(1, 0);
        chk("set_min_mode", mode, 2);
        chk("set_min_val", load_val, 58);
        tap(0, 1); chk("inc_59", load_val, 59);
        tap(0, 1); chk("inc_wrap_min", load_val, 0);
        sbq.push_back({3'b011, 6'd0, 2'b00});
        tap(1, 0);
        chk("commit_mode", mode, 0);
        chk("commit_sb_empty", sbq.size(), 0);
        found = 0;
        for (int i = 0; i < 8 && found == 0; i++) begin
            @(negedge clk);
            if (en) found = 1;
        end
        chk("en_resumes", found, 1);

        count_hrs = 6'd7;
        btn_mode = 1'b1;
        toggles = 0; dwell = 0; pb = blink;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 2) btn_mode = 1'b0;
            if (blink != pb) toggles++;
            pb = blink;
            if (mode == 2'd1) dwell++;
            else if (dwell != 0) break;
        end
        chk("timeout_mode", mode, 0);
        chk("timeout_toggles", toggles, 2);
        chk("timeout_dwell_ok", {31'd0, dwell >= 9 && dwell <= 12}, 1);
        chk("timeout_blink_off", blink, 0);

        count_hrs = 6'd5;
        count_min = 6'd33;
        @(posedge clk); #1;
        tap(1, 0);
        chk("simul_pre_val", load_val, 5);
        sbq.push_back({3'b100, 6'd5, 2'b10});
        tap(1, 1);
        chk("simul_mode", mode, 2);
        chk("simul_val", load_val, 33);
        for (int i = 0; i < 20 && mode != 2'd0; i++) @(negedge clk);
        chk("simul_timeout_mode", mode, 0);

        count_hrs = 6'd3;
        count_min = 6'd10;
        @(posedge clk); #1;
        tap(1, 0);
        sbq.push_back({3'b100, 6'd3, 2'b10});
        tap(1, 0);
        tap(0, 1);
        tap(0, 1);
        chk("pre_reset_val", load_val, 12);
        chk("pre_reset_mode", mode, 2);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_outs", {en, load_hrs, load_min, clr_sec_req, blink}, 0);
        chk("mid_rst_val", load_val, 0);
        chk("mid_rst_mode", mode, 0);
        repeat (3) @(negedge clk);
        chk("held_rst_mode", mode, 0);
        reset = 1'b1;
        first_en("first_en_after_mid_rst");
        repeat (30) @(negedge clk);
        chk("post_rst_mode", mode, 0);
        chk("sb_drained", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
